// File: rtl/eaf_filter_ctrl.sv
// eaf_filter_ctrl
// Evicted Address Filter sequencer. Takes insert/test requests, hashes the
// line address in two stages and reads (and for inserts, sets) one bit in each
// of seven power-of-two bit arrays (2, 4, 8, 32, 128, 2048, 8192 bits).
// After max_num_of_entries inserts the whole filter is swept to zero.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE)
//   req_insert      1 = insert, 0 = test
//   req_addr        line address
//   resp_valid      one-cycle response pulse, 3 cycles after accept
//   resp_hit        all seven indexed bits were set before any update
//   resp_is_insert  echo of the request's insert flag
//   clearing        clear sweep in progress
//   insert_count    inserts since the last clear
//
// state  | meaning
// CLEAR  | zero one 256-bit slice of the big array per cycle (small ones at idx 0)
// IDLE   | ready for a request
// HASH   | first hash stage registered
// LOOKUP | second hash stage, read/update arrays, launch response
module eaf_filter_ctrl #(
  parameter int addr_length         = 32,
  parameter int max_num_of_entries  = 8,
  parameter int num_of_counter_bits = $clog2(max_num_of_entries) + 1,
  parameter int clr_width           = 256,
  parameter int clr_cycles          = 8192 / clr_width
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_insert,
  input  logic [addr_length-1:0]         req_addr,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic                           resp_is_insert,
  output logic                           clearing,
  output logic [num_of_counter_bits-1:0] insert_count
);

  localparam int clr_idx_bits = (clr_cycles > 1) ? $clog2(clr_cycles) : 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_HASH, ST_LOOKUP} state_t;

  state_t                         state, state_next;
  logic [clr_idx_bits-1:0]        clr_idx;
  logic [addr_length-1:0]         addr_q;
  logic                           insert_q;
  logic [31:0]                    x_q;

  logic [1:0]                     arr1;
  logic [3:0]                     arr2;
  logic [7:0]                     arr3;
  logic [31:0]                    arr5;
  logic [127:0]                   arr7;
  logic [2047:0]                  arr11;
  logic [8191:0]                  arr13;

  logic [31:0]                    a32, a_mix, x_hash, x_mix, y;
  logic                           hit, last_clr, count_full;
  logic [num_of_counter_bits-1:0] count_inc;
  logic                           unused_y_hi;

  assign a32    = 32'(addr_q);
  assign a_mix  = a32 ^ (a32 >> 16);
  assign x_hash = a_mix * 32'h5555_5555;
  assign x_mix  = x_q ^ (x_q >> 16);
  assign y      = x_mix * 32'h9e37_79b9;
  // only the low 13 bits of y index the arrays
  assign unused_y_hi = ^y[31:13];

  assign hit = arr1[y[0]] & arr2[y[1:0]] & arr3[y[2:0]] & arr5[y[4:0]] &
               arr7[y[6:0]] & arr11[y[10:0]] & arr13[y[12:0]];

  assign last_clr   = (clr_idx == clr_idx_bits'(clr_cycles - 1));
  assign count_inc  = insert_count + num_of_counter_bits'(1);
  assign count_full = (count_inc == num_of_counter_bits'(max_num_of_entries));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR:  if (last_clr) state_next = ST_IDLE;
      ST_IDLE:   if (req_valid) state_next = ST_HASH;
      ST_HASH:   state_next = ST_LOOKUP;
      ST_LOOKUP: state_next = (insert_q && count_full) ? ST_CLEAR : ST_IDLE;
      default:   state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    clearing  = (state == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx        <= '0;
      addr_q         <= '0;
      insert_q       <= 1'b0;
      x_q            <= '0;
      insert_count   <= '0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_is_insert <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_CLEAR: clr_idx <= last_clr ? '0 : clr_idx + clr_idx_bits'(1);
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            insert_q <= req_insert;
          end
        end
        ST_HASH: x_q <= x_hash;
        ST_LOOKUP: begin
          resp_valid     <= 1'b1;
          resp_hit       <= hit;
          resp_is_insert <= insert_q;
          if (insert_q) begin
            // the count restarts as the sweep begins
            insert_count <= count_full ? '0 : count_inc;
            clr_idx      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Filter storage has no reset; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      arr13[int'(clr_idx) * clr_width +: clr_width] <= '0;
      if (clr_idx == '0) begin
        arr1  <= '0;
        arr2  <= '0;
        arr3  <= '0;
        arr5  <= '0;
        arr7  <= '0;
        arr11 <= '0;
      end
    end else if (state == ST_LOOKUP && insert_q) begin
      arr1[y[0]]      <= 1'b1;
      arr2[y[1:0]]    <= 1'b1;
      arr3[y[2:0]]    <= 1'b1;
      arr5[y[4:0]]    <= 1'b1;
      arr7[y[6:0]]    <= 1'b1;
      arr11[y[10:0]]  <= 1'b1;
      arr13[y[12:0]]  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eaf_filter_ctrl.sv
module tb_eaf_filter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_insert = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_valid, resp_hit, resp_is_insert, clearing;
  logic [3:0]  insert_count;

  int total = 0;
  int bad   = 0;

  // reference filter contents and insert count
  logic [8191:0] mdl [7];
  int            mcount = 0;
  localparam int P [7] = '{1, 2, 3, 5, 7, 11, 13};

  eaf_filter_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_insert(req_insert), .req_addr(req_addr), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_is_insert(resp_is_insert), .clearing(clearing),
    .insert_count(insert_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hash_y(input logic [31:0] a);
    logic [31:0] x, t;
    t = a ^ (a >> 16);
    x = t * 32'h5555_5555;
    t = x ^ (x >> 16);
    return t * 32'h9e37_79b9;
  endfunction

  function automatic logic model_hit(input logic [31:0] y);
    logic h = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [31:0] idx;
      idx = y & ((32'd1 << P[k]) - 32'd1);
      h &= mdl[k][idx[12:0]];
    end
    return h;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 7; k++) mdl[k] = '0;
    mcount = 0;
  endtask

  task automatic model_insert(input logic [31:0] y);
    for (int k = 0; k < 7; k++) begin
      logic [31:0] idx;
      idx = y & ((32'd1 << P[k]) - 32'd1);
      mdl[k][idx[12:0]] = 1'b1;
    end
    mcount++;
    if (mcount == 8) model_clear();
  endtask

  // Count consecutive sampled cycles with clearing high, starting at the current negedge.
  task automatic measure_clear(input string tag, input int exp_resp);
    int n = 0, nresp = 0, nready = 0;
    while (clearing === 1'b1 && n < 200) begin
      n++;
      if (resp_valid === 1'b1) nresp++;
      if (req_ready !== 1'b0) nready++;
      @(negedge clk);
    end
    check({tag, "_clear_len"}, n, 32);
    check({tag, "_clear_resp"}, nresp, exp_resp);
    check({tag, "_clear_ready"}, nready, 0);
  endtask

  // exp_hit < 0 means take the expectation from the reference filter.
  task automatic do_req(input string tag, input logic ins, input logic [31:0] addr, input int exp_hit);
    int wait_n = 0, lat = 1;
    logic [31:0] y;
    logic eh, full;
    req_insert = ins;
    req_addr   = addr;
    req_valid  = 1'b1;
    while (req_ready !== 1'b1 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_ready_wait"}, (wait_n < 200), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (resp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    y  = hash_y(addr);
    eh = (exp_hit < 0) ? model_hit(y) : exp_hit[0];
    if (ins) model_insert(y);
    full = ins && (mcount == 0);
    check({tag, "_hit"}, resp_hit, eh);
    check({tag, "_is_insert"}, resp_is_insert, ins);
    check({tag, "_count"}, insert_count, mcount);
    check({tag, "_clearing"}, clearing, full);
  endtask

  initial begin
    logic [31:0] y;
    model_clear();

    // reset with a request already pending
    req_valid  = 1'b1;
    req_addr   = 32'h0000_1040;
    req_insert = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_is_insert", resp_is_insert, 0);
    check("rst_clearing", clearing, 1);
    check("rst_count", insert_count, 0);
    rst = 1'b0;
    measure_clear("init", 0);
    check("init_ready_after", req_ready, 1);

    do_req("test_empty", 1'b0, 32'h0000_1040, 0);
    do_req("ins_1040", 1'b1, 32'h0000_1040, 0);
    y = hash_y(32'h0000_1040);
    check("bit_p1", dut.arr1[y[0]], 1);
    check("bit_p2", dut.arr2[y[1:0]], 1);
    check("bit_p3", dut.arr3[y[2:0]], 1);
    check("bit_p5", dut.arr5[y[4:0]], 1);
    check("bit_p7", dut.arr7[y[6:0]], 1);
    check("bit_p11", dut.arr11[y[10:0]], 1);
    check("bit_p13", dut.arr13[y[12:0]], 1);
    do_req("test_1040", 1'b0, 32'h0000_1040, 1);
    do_req("ins_1040_again", 1'b1, 32'h0000_1040, 1);

    // fresh filter for the auto-clear run
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    measure_clear("rst2", 0);
    for (int i = 1; i <= 8; i++) begin
      do_req($sformatf("ins8_%0d", i), 1'b1, 32'(i) << 8, -1);
    end
    measure_clear("auto", 1);
    check("auto_count", insert_count, 0);
    do_req("test_100_after_clear", 1'b0, 32'h0000_0100, 0);

    // reset while an insert is in HASH
    req_insert = 1'b1;
    req_addr   = 32'h0000_2468;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("hash_state", dut.state, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    measure_clear("rst_hash", 0);
    check("rst_hash_count", insert_count, 0);
    do_req("test_dropped", 1'b0, 32'h0000_2468, 0);

    // reset in the middle of a sweep
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (17) @(negedge clk);
    check("sweep_idx17", dut.clr_idx, 17);
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_idx0", dut.clr_idx, 0);
    rst = 1'b0;
    measure_clear("rst_sweep", 0);
    do_req("test_final", 1'b0, 32'h0000_1040, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
